frequency_divider: RTL and testbench
====================================

// Module: frequency_divider
// PURPOSE
//   Integer clock divider: derives clk_out from clk_in at f(clk_in)/DIV.
//   Free-running after reset, no enable or handshake.
//   Used to produce slow tick/clock domains from the system clock.
//   Even DIV gives exact 50% duty. Odd DIV gives either a near-50% duty
//   (single-edge logic) or an exact 50% duty (dual-edge logic), selected by parameter.
// PARAMETERS
//   DIV           2  division ratio, integer >= 2; DIV < 2 is an elaboration error ($error)
//   ODD_BALANCED  0  odd DIV only: 0 = rising-edge logic only, high (DIV+1)/2 cycles;
//                    1 = exact 50% duty using an extra falling-edge flop
// PORTS
//   clk_in   in   1  input clock; the only clock (falling edge used only when DIV odd and ODD_BALANCED=1)
//   rst      in   1  reset, asynchronous, active-high
//   clk_out  out  1  divided clock, registered (glitch-free)
// BEHAVIOUR
//   - Clock and reset: one clock, clk_in. Reset rst is asynchronous and active-high.
//   - Reset: while rst=1, counter cnt=0 and all output flops are 0, so clk_out=0.
//     Asserting rst mid-operation forces clk_out=0 immediately, without waiting for a clock edge.
//   - Counter: cnt is $clog2(DIV) bits wide.
//     It increments on each clk_in rising edge and wraps from DIV-1 to 0.
//   - Even DIV:
//     - pos_q toggles on a rising edge when cnt==DIV/2-1 or cnt==DIV-1.
//     - clk_out = pos_q.
//     - First rising edge after rst deasserts drives clk_out to 1.
//     - Period is DIV input cycles; high for DIV/2, low for DIV/2.
//     - DIV=2 reduces to a toggle on every rising edge.
//   - Odd DIV, ODD_BALANCED=0:
//     - pos_q is 1 for cnt in {0..(DIV-1)/2} as seen after each edge.
//     - Concretely: pos_q is set on a rising edge when the next cnt is 0, and cleared when the next cnt is (DIV+1)/2.
//     - clk_out = pos_q.
//     - High for (DIV+1)/2 cycles, low for (DIV-1)/2 cycles.
//     - First rising edge after reset drives clk_out to 1.
//   - Odd DIV, ODD_BALANCED=1:
//     - pos_q is high for (DIV-1)/2 rising-edge cycles.
//     - neg_q samples pos_q on each clk_in falling edge.
//     - clk_out = pos_q | neg_q, giving high time DIV/2 input periods (exact 50%).
//     - This OR is the only combinational output path. It is glitch-free because its inputs change on opposite edges.
//   - Latency: 1 rising edge after reset release to the first clk_out high. No other timing dependencies.
//   - Wrap-around: the cnt wrap is seamless. Period is constant in steady state, with no missing or extra pulse.
//   - Reset release between edges: counting starts at the next rising edge, with no partial cycle.
// TESTING
//   - DIV=2, clk_in period 20 ns, rst=1 for 0-25 ns:
//     - clk_out=0 until 30 ns.
//     - Then 1@30, 0@50, 1@70, and so on: period 40 ns, 50% duty.
//   - DIV=4: clk_out rises on the 1st edge after reset, falls on the 3rd, rises on the 5th.
//     Period 4 cycles, high 2 cycles.
//   - DIV=5, ODD_BALANCED=0: high 3 cycles, low 2 cycles, repeating with period 5 cycles.
//   - DIV=5, ODD_BALANCED=1: high exactly 2.5 input periods, low 2.5 input periods.
//     Check with a high-time measurement in $time.
//   - Reset mid-operation, with clk_out=1: assert rst off-edge.
//     - clk_out goes to 0 in the same timestep.
//     - After release, the sequence restarts as from power-up.
//   - Long run, 1000 ns or 100 DIV periods: count clk_out rising edges.
//     Expected count is floor(input edges after reset / DIV), within +-1.

Source files
------------

// File: rtl/frequency_divider.sv
// -----------------------------------------------------------------------------
// frequency_divider
//   Integer clock divider: clk_out runs at f(clk_in)/DIV and is free-running
//   after reset. Even DIV gives an exact 50% duty cycle. For odd DIV,
//   ODD_BALANCED selects between two forms:
//     0 = rising-edge logic only; high for (DIV+1)/2 cycles, low for (DIV-1)/2.
//     1 = an extra falling-edge flop stretches the high phase by half a
//         period, giving an exact 50% duty cycle.
//
// Parameters
//   DIV           division ratio, integer >= 2
//   ODD_BALANCED  odd DIV only: 0 = single-edge logic, 1 = dual-edge 50% duty
//
// Ports
//   clk_in   in   input clock (falling edge used only when DIV is odd and
//                 ODD_BALANCED=1)
//   rst      in   asynchronous, active-high reset
//   clk_out  out  divided clock, glitch-free
// -----------------------------------------------------------------------------
module frequency_divider #(
    parameter int DIV          = 2,
    parameter int ODD_BALANCED = 0
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out
);

    localparam int CW       = (DIV < 2) ? 1 : $clog2(DIV);
    localparam bit IS_ODD   = (DIV % 2) != 0;
    localparam bit BALANCED = IS_ODD && (ODD_BALANCED != 0);

    localparam logic [CW-1:0] CNT_MAX      = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ODD_HIGH = CW'((DIV - 1) / 2);

    generate
        if (DIV < 2) begin : g_div_check
            $error("frequency_divider: DIV must be >= 2 (got %0d)", DIV);
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          pos_q;
    logic          pos_d;

    // Output decisions are made on the count being loaded at this edge, so
    // the first rising edge after reset (cnt 0 -> 1) already opens the high
    // phase.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cnt_next = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        pos_d    = pos_q;
        if (!IS_ODD) begin
            if ((cnt_next == CNT_HALF_M1) || (cnt_next == CNT_MAX)) begin
                pos_d = ~pos_q;
            end
        end else if (!BALANCED) begin
            // High for counts 0..(DIV-1)/2, i.e. (DIV+1)/2 cycles.
            pos_d = (cnt_next <= CNT_ODD_HIGH);
        end else begin
            // High for counts 1..(DIV-1)/2; the falling-edge flop adds the
            // missing half period.
            pos_d = (cnt_next != '0) && (cnt_next <= CNT_ODD_HIGH);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pos_q <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            pos_q <= pos_d;
        end
    end

    generate
        if (BALANCED) begin : g_balanced
            logic neg_q;

            always_ff @(negedge clk_in or posedge rst) begin
                if (rst) begin
                    neg_q <= 1'b0;
                end else begin
                    neg_q <= pos_q;
                end
            end

            // pos_q and neg_q change on opposite clock edges, so this OR
            // never sees both inputs move at once and cannot glitch.
            assign clk_out = pos_q | neg_q;
        end else begin : g_single_edge
            assign clk_out = pos_q;
        end
    endgenerate

endmodule

// File: tb/tb_frequency_divider.sv
// -----------------------------------------------------------------------------
// tb_frequency_divider
//   Directed bench for frequency_divider. Four instances share clk_in/rst:
//   DIV=2, DIV=4, DIV=5 single-edge and DIV=5 balanced. clk_in period is 20,
//   rising edges at 10, 30, 50, ...; rst is high from 0 to 25, so rising
//   edge n after release lands at 30 + 20*(n-1). Outputs are sampled 5 time
//   units after a rising edge, before the following falling edge.
// -----------------------------------------------------------------------------
module tb_frequency_divider;

    logic clk_in;
    logic rst;
    logic co_d2;
    logic co_d4;
    logic co_d5;
    logic co_d5b;

    int n_checks = 0;
    int n_errors = 0;

    // Expected clk_out right after rising edges 1..10 after reset release,
    // bit i = edge i+1.
    logic [9:0] exp_d2  = 10'b0101010101;  // 1,0,1,0,...
    logic [9:0] exp_d4  = 10'b1100110011;  // 1,1,0,0,1,1,0,0,1,1
    logic [9:0] exp_d5  = 10'b1001110011;  // 1,1,0,0,1,1,1,0,0,1
    logic [9:0] exp_d5b = 10'b0011100111;  // 1,1,1,0,0,1,1,1,0,0

    // Balanced-output pulse timing and long-run edge counters.
    time rise_t    = 0;
    time fall_t    = 0;
    time high_time = 0;
    time low_time  = 0;
    bit  fall_seen = 1'b0;
    int  rc_d2 = 0;
    int  rc_d4 = 0;
    int  rc_d5 = 0;
    int  rc_d5b = 0;

    frequency_divider #(.DIV(2), .ODD_BALANCED(0)) u_d2 (
        .clk_in (clk_in),
        .rst    (rst),
        .clk_out(co_d2)
    );

    frequency_divider #(.DIV(4), .ODD_BALANCED(0)) u_d4 (
        .clk_in (clk_in),
        .rst    (rst),
        .clk_out(co_d4)
    );

    frequency_divider #(.DIV(5), .ODD_BALANCED(0)) u_d5 (
        .clk_in (clk_in),
        .rst    (rst),
        .clk_out(co_d5)
    );

    frequency_divider #(.DIV(5), .ODD_BALANCED(1)) u_d5b (
        .clk_in (clk_in),
        .rst    (rst),
        .clk_out(co_d5b)
    );

    initial clk_in = 1'b0;
    always #10 clk_in = ~clk_in;

    always @(posedge co_d5b) begin
        if (fall_seen) low_time = $time - fall_t;
        rise_t = $time;
    end

    always @(negedge co_d5b) begin
        high_time = $time - rise_t;
        fall_t    = $time;
        fall_seen = 1'b1;
    end

    always @(posedge co_d2)  rc_d2++;
    always @(posedge co_d4)  rc_d4++;
    always @(posedge co_d5)  rc_d5++;
    always @(posedge co_d5b) rc_d5b++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called 5 time units after rising edge 1; returns 5 after edge 11.
    task automatic run_pattern(input string phase);
        for (int n = 0; n < 10; n++) begin
            check($sformatf("%s_d2_e%0d", phase, n + 1),  32'(co_d2),  32'(exp_d2[n]));
            check($sformatf("%s_d4_e%0d", phase, n + 1),  32'(co_d4),  32'(exp_d4[n]));
            check($sformatf("%s_d5_e%0d", phase, n + 1),  32'(co_d5),  32'(exp_d5[n]));
            check($sformatf("%s_d5b_e%0d", phase, n + 1), 32'(co_d5b), 32'(exp_d5b[n]));
            #20;
        end
    endtask

    initial begin
        rst = 1'b1;

        // t=15: a rising edge occurred at 10 while in reset.
        #15;
        check("rst_d2",  32'(co_d2),  0);
        check("rst_d4",  32'(co_d4),  0);
        check("rst_d5",  32'(co_d5),  0);
        check("rst_d5b", 32'(co_d5b), 0);

        // Release between edges; nothing may move before the edge at 30.
        #10 rst = 1'b0;
        #4;
        check("pre_d2",  32'(co_d2),  0);
        check("pre_d4",  32'(co_d4),  0);
        check("pre_d5",  32'(co_d5),  0);
        check("pre_d5b", 32'(co_d5b), 0);

        #6;
        run_pattern("init");

        // t=235: balanced DIV=5 second pulse high 130..180, next rise at 230.
        check("d5b_high_time", 32'(high_time), 50);
        check("d5b_low_time",  32'(low_time),  50);

        // t=275, after edge 13: DIV=2, DIV=4 and DIV=5 balanced are high.
        #40;
        check("mid_d2",  32'(co_d2),  1);
        check("mid_d4",  32'(co_d4),  1);
        check("mid_d5",  32'(co_d5),  0);
        check("mid_d5b", 32'(co_d5b), 1);

        // Off-edge reset must clear the outputs before any clock edge.
        rst = 1'b1;
        #1;
        check("async_d2",  32'(co_d2),  0);
        check("async_d4",  32'(co_d4),  0);
        check("async_d5",  32'(co_d5),  0);
        check("async_d5b", 32'(co_d5b), 0);

        // Release at 285; first edge at 290 restarts from power-up state.
        #9 rst = 1'b0;
        #10;
        run_pattern("restart");

        // t=495: long run of 200 rising edges (510..4490) after a fresh reset.
        rst    = 1'b1;
        rc_d2  = 0;
        rc_d4  = 0;
        rc_d5  = 0;
        rc_d5b = 0;
        #10 rst = 1'b0;
        #3990;
        check("long_d2", 32'(rc_d2), 100);
        check("long_d4", 32'(rc_d4), 50);
        check("long_d5_within1",  32'((rc_d5 >= 39) && (rc_d5 <= 41)), 1);
        check("long_d5b_within1", 32'((rc_d5b >= 39) && (rc_d5b <= 41)), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
